btn_event_decoder: RTL and testbench

BTN_EVENT_DECODER -- requirements
Module: btn_event_decoder

---
 rtl/btn_event_decoder.sv | 188 ++++++++++++++++++
 tb/tb_btn_event_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: turns debounced button levels into press, short,
// long, auto-repeat and release pulses, plus a per-channel held level.
//
// Ports:
//   iClk           - single clock, rising edge
//   iRstn          - asynchronous active-low reset (released synchronously)
//   iBtnDebounced  - debounced, synchronous, active-high button levels
//   oPressPulse    - 1-cycle pulse when a channel is pressed
//   oShortPulse    - 1-cycle pulse on release before the long threshold
//   oLongPulse     - 1-cycle pulse when the long threshold is reached
//   oRepeatPulse   - 1-cycle pulse per repeat interval while long-held
//   oReleasePulse  - 1-cycle pulse on any release
//   oHeld          - high while the channel is PRESSED or LONG

module btn_event_decoder #(
    parameter int P_NUM_BTN   = 5,
    parameter int P_CLK_HZ    = 100000000,
    parameter int P_LONG_MS   = 1000,
    parameter int P_REPEAT_MS = 200,
    parameter int P_REPEAT_EN = 1
) (
    input  logic                 iClk,
    input  logic                 iRstn,
    input  logic [P_NUM_BTN-1:0] iBtnDebounced,
    output logic [P_NUM_BTN-1:0] oPressPulse,
    output logic [P_NUM_BTN-1:0] oShortPulse,
    output logic [P_NUM_BTN-1:0] oLongPulse,
    output logic [P_NUM_BTN-1:0] oRepeatPulse,
    output logic [P_NUM_BTN-1:0] oReleasePulse,
    output logic [P_NUM_BTN-1:0] oHeld
);

    localparam int PRESC_N = P_CLK_HZ / 1000;
    localparam int PRESC_W = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
    localparam int HOLD_W  = $clog2(P_LONG_MS + 1);
    localparam int REP_W   = $clog2(P_REPEAT_MS + 1);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC_N - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(P_LONG_MS);
    localparam logic [REP_W-1:0]   REP_MAX   = REP_W'(P_REPEAT_MS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_e;

    // Shared millisecond prescaler
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               tick;

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + PRESC_W'(1);
    end

    // Per-channel state
    logic [P_NUM_BTN-1:0] prev_q;
    logic [P_NUM_BTN-1:0] prev_d;
    state_e               state_q [P_NUM_BTN];
    state_e               state_d [P_NUM_BTN];
    logic [HOLD_W-1:0]    hold_q  [P_NUM_BTN];
    logic [HOLD_W-1:0]    hold_d  [P_NUM_BTN];
    logic [REP_W-1:0]     rep_q   [P_NUM_BTN];
    logic [REP_W-1:0]     rep_d   [P_NUM_BTN];

    logic [P_NUM_BTN-1:0] press_q;
    logic [P_NUM_BTN-1:0] press_d;
    logic [P_NUM_BTN-1:0] short_q;
    logic [P_NUM_BTN-1:0] short_d;
    logic [P_NUM_BTN-1:0] long_q;
    logic [P_NUM_BTN-1:0] long_d;
    logic [P_NUM_BTN-1:0] repeat_q;
    logic [P_NUM_BTN-1:0] repeat_d;
    logic [P_NUM_BTN-1:0] release_q;
    logic [P_NUM_BTN-1:0] release_d;
    logic [P_NUM_BTN-1:0] held_q;
    logic [P_NUM_BTN-1:0] held_d;

    logic [P_NUM_BTN-1:0] rise;
    logic [P_NUM_BTN-1:0] fall;

    assign rise = ~prev_q & iBtnDebounced;
    assign fall = prev_q & ~iBtnDebounced;

    always_comb begin
        prev_d    = iBtnDebounced;
        press_d   = '0;
        short_d   = '0;
        long_d    = '0;
        repeat_d  = '0;
        release_d = '0;
        held_d    = '0;
        for (int i = 0; i < P_NUM_BTN; i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            rep_d[i]   = rep_q[i];

            unique case (state_q[i])
                ST_IDLE: begin
                    // A fall here (button held through reset) is ignored
                    if (rise[i]) begin
                        state_d[i] = ST_PRESSED;
                        hold_d[i]  = '0;
                        press_d[i] = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    // Release wins over a coincident tick
                    if (fall[i]) begin
                        state_d[i]   = ST_IDLE;
                        short_d[i]   = 1'b1;
                        release_d[i] = 1'b1;
                    end else if (tick) begin
                        if (hold_q[i] >= HOLD_MAX - HOLD_W'(1)) begin
                            hold_d[i]  = HOLD_MAX;
                            state_d[i] = ST_LONG;
                            rep_d[i]   = '0;
                            long_d[i]  = 1'b1;
                        end else begin
                            hold_d[i] = hold_q[i] + HOLD_W'(1);
                        end
                    end
                end
                ST_LONG: begin
                    if (fall[i]) begin
                        state_d[i]   = ST_IDLE;
                        release_d[i] = 1'b1;
                    end else if (tick && (P_REPEAT_EN != 0)) begin
                        if (rep_q[i] >= REP_MAX - REP_W'(1)) begin
                            rep_d[i]    = '0;
                            repeat_d[i] = 1'b1;
                        end else begin
                            rep_d[i] = rep_q[i] + REP_W'(1);
                        end
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase

            held_d[i] = (state_d[i] != ST_IDLE);
        end
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            presc_q   <= '0;
            // All-ones so a button held through reset is not a press
            prev_q    <= '1;
            press_q   <= '0;
            short_q   <= '0;
            long_q    <= '0;
            repeat_q  <= '0;
            release_q <= '0;
            held_q    <= '0;
            for (int i = 0; i < P_NUM_BTN; i++) begin
                state_q[i] <= ST_IDLE;
                hold_q[i]  <= '0;
                rep_q[i]   <= '0;
            end
        end else begin
            presc_q   <= presc_d;
            prev_q    <= prev_d;
            press_q   <= press_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            release_q <= release_d;
            held_q    <= held_d;
            for (int i = 0; i < P_NUM_BTN; i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
                rep_q[i]   <= rep_d[i];
            end
        end
    end

    assign oPressPulse   = press_q;
    assign oShortPulse   = short_q;
    assign oLongPulse    = long_q;
    assign oRepeatPulse  = repeat_q;
    assign oReleasePulse = release_q;
    assign oHeld         = held_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb_btn_event_decoder: directed bench for btn_event_decoder with a
// 10-cycle ms tick, long threshold 5 ms and repeat interval 2 ms.

module tb_btn_event_decoder;

    localparam int NB = 5;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic [NB-1:0] btn  = '0;

    logic [NB-1:0] press, short_p, long_p, rep_p, rel_p, held;
    logic [NB-1:0] press_b, short_b, long_b, rep_b, rel_b, held_b;

    btn_event_decoder #(
        .P_NUM_BTN(NB), .P_CLK_HZ(10000), .P_LONG_MS(5),
        .P_REPEAT_MS(2), .P_REPEAT_EN(1)
    ) dut (
        .iClk(clk), .iRstn(rstn), .iBtnDebounced(btn),
        .oPressPulse(press), .oShortPulse(short_p),
        .oLongPulse(long_p), .oRepeatPulse(rep_p),
        .oReleasePulse(rel_p), .oHeld(held)
    );

    btn_event_decoder #(
        .P_NUM_BTN(NB), .P_CLK_HZ(10000), .P_LONG_MS(5),
        .P_REPEAT_MS(2), .P_REPEAT_EN(0)
    ) dut_norep (
        .iClk(clk), .iRstn(rstn), .iBtnDebounced(btn),
        .oPressPulse(press_b), .oShortPulse(short_b),
        .oLongPulse(long_b), .oRepeatPulse(rep_b),
        .oReleasePulse(rel_b), .oHeld(held_b)
    );

    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse recorder: counts and last-seen cycle per channel
    int n_press [NB], n_short [NB], n_long [NB], n_rep [NB], n_rel [NB];
    int t_press [NB], t_short [NB], t_long [NB], t_rel [NB];
    int n_long_b [NB], n_rep_b [NB], n_any_b [NB];
    int rep1_t [$];

    always @(negedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (press[i])   begin n_press[i] += 1; t_press[i] = cyc; end
            if (short_p[i]) begin n_short[i] += 1; t_short[i] = cyc; end
            if (long_p[i])  begin n_long[i]  += 1; t_long[i]  = cyc; end
            if (rel_p[i])   begin n_rel[i]   += 1; t_rel[i]   = cyc; end
            if (rep_p[i]) begin
                n_rep[i] += 1;
                if (i == 1) rep1_t.push_back(cyc);
            end
            if (long_b[i]) n_long_b[i] += 1;
            if (rep_b[i])  n_rep_b[i]  += 1;
            if (press_b[i] | short_b[i] | rel_b[i]) n_any_b[i] += 1;
        end
    end

    int s_press [NB], s_short [NB], s_long [NB], s_rep [NB], s_rel [NB];
    int s_long_b [NB], s_rep_b [NB], s_any_b [NB];
    int s_rep1;

    int n_chk;
    int n_err;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic go(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        s_press  = n_press;
        s_short  = n_short;
        s_long   = n_long;
        s_rep    = n_rep;
        s_rel    = n_rel;
        s_long_b = n_long_b;
        s_rep_b  = n_rep_b;
        s_any_b  = n_any_b;
        s_rep1   = rep1_t.size();
    endtask

    function automatic int all_delta();
        int s;
        s = 0;
        for (int i = 0; i < NB; i++) begin
            s += n_press[i] - s_press[i] + n_short[i] - s_short[i];
            s += n_long[i] - s_long[i] + n_rep[i] - s_rep[i];
            s += n_rel[i] - s_rel[i];
            s += n_long_b[i] - s_long_b[i] + n_rep_b[i] - s_rep_b[i];
            s += n_any_b[i] - s_any_b[i];
        end
        return s;
    endfunction

    function automatic int rep_b_delta();
        int s;
        s = 0;
        for (int i = 0; i < NB; i++) s += n_rep_b[i] - s_rep_b[i];
        return s;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, c1, lat, nr, ph, x;
        n_chk = 0;
        n_err = 0;

        // Reset with random inputs: everything stays low
        for (int k = 0; k < 4; k++) begin
            btn = NB'($urandom);
            go(1);
            chk("rst_out", int'({press, short_p, long_p, rep_p, rel_p, held}), 0);
            chk("rst_out_b", int'({press_b, short_b, long_b, rep_b, rel_b, held_b}), 0);
        end

        // ch2 held through reset release: silent until low then high
        btn = 5'b00100;
        go(1);
        rstn = 1'b1;
        snap();
        go(30);
        chk("rst_hold_events", all_delta(), 0);
        chk("rst_hold_held", int'(held), 0);
        btn[2] = 1'b0;
        go(3);
        btn[2] = 1'b1;
        c0 = cyc;
        go(3);
        chk("ch2_press_cnt", n_press[2] - s_press[2], 1);
        chk("ch2_press_t", t_press[2], c0 + 1);
        chk("ch2_held", int'(held), 5'b00100);
        btn[2] = 1'b0;
        go(3);

        // Short press on ch0
        snap();
        btn[0] = 1'b1;
        c0 = cyc;
        go(1);
        chk("ch0_press_now", int'(press), 5'b00001);
        go(1);
        chk("ch0_press_width", int'(press), 0);
        go(18);
        chk("ch0_held", int'(held), 5'b00001);
        btn[0] = 1'b0;
        c1 = cyc;
        go(1);
        chk("ch0_short_rel", int'({short_p[0], rel_p[0]}), 3);
        go(4);
        chk("ch0_press_cnt", n_press[0] - s_press[0], 1);
        chk("ch0_short_cnt", n_short[0] - s_short[0], 1);
        chk("ch0_short_t", t_short[0], c1 + 1);
        chk("ch0_long_cnt", n_long[0] - s_long[0], 0);
        chk("ch0_held_off", int'(held), 0);

        // Long press with auto-repeat on ch1
        snap();
        btn[1] = 1'b1;
        c0 = cyc;
        go(120);
        btn[1] = 1'b0;
        c1 = cyc;
        go(30);
        lat = t_long[1] - t_press[1];
        chk("ch1_press_t", t_press[1], c0 + 1);
        chk("ch1_long_cnt", n_long[1] - s_long[1], 1);
        chk("ch1_lat_41_50", int'(lat >= 41 && lat <= 50), 1);
        nr = rep1_t.size() - s_rep1;
        chk("ch1_rep_cnt", nr, 3);
        for (int k = 0; k < nr && k < 3; k++) begin
            chk("ch1_rep_gap",
                rep1_t[s_rep1 + k] - ((k == 0) ? t_long[1] : rep1_t[s_rep1 + k - 1]),
                20);
        end
        chk("ch1_rel_cnt", n_rel[1] - s_rel[1], 1);
        chk("ch1_rel_t", t_rel[1], c1 + 1);
        chk("ch1_short_cnt", n_short[1] - s_short[1], 0);
        chk("ch1_norep_long", n_long_b[1] - s_long_b[1], 1);
        chk("ch1_norep_rep", rep_b_delta(), 0);
        ph = t_long[1] % 10;

        // ch0 and ch4 together: ch0 short, ch4 long
        snap();
        btn[0] = 1'b1;
        btn[4] = 1'b1;
        c0 = cyc;
        go(10);
        chk("sim_held_both", int'(held), 5'b10001);
        go(10);
        btn[0] = 1'b0;
        go(10);
        chk("sim_held_ch4", int'(held), 5'b10000);
        go(50);
        btn[4] = 1'b0;
        go(10);
        chk("sim_held_none", int'(held), 0);
        chk("sim_press_t0", t_press[0], c0 + 1);
        chk("sim_press_t4", t_press[4], c0 + 1);
        chk("sim_ch0_short", n_short[0] - s_short[0], 1);
        chk("sim_ch0_long", n_long[0] - s_long[0], 0);
        chk("sim_ch4_long", n_long[4] - s_long[4], 1);
        chk("sim_ch4_short", n_short[4] - s_short[4], 0);
        chk("sim_ch4_rep", n_rep[4] - s_rep[4], 1);
        chk("sim_ch4_rel_t", t_rel[4], c0 + 81);

        // ch3 released on the tick that would make it long
        for (int k = 0; k < 20 && (cyc % 10) != ph; k++) go(1);
        snap();
        btn[3] = 1'b1;
        x = cyc;
        go(49);
        btn[3] = 1'b0;
        go(5);
        chk("ch3_press_t", t_press[3], x + 1);
        chk("ch3_short_cnt", n_short[3] - s_short[3], 1);
        chk("ch3_rel_cnt", n_rel[3] - s_rel[3], 1);
        chk("ch3_short_t", t_short[3], x + 50);
        chk("ch3_long_cnt", n_long[3] - s_long[3], 0);
        chk("ch3_long_b_cnt", n_long_b[3] - s_long_b[3], 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
